// File: rtl/aq_f_spsram_gen.sv
// aq_f_spsram_gen: parametrised single-port SRAM wrapper with per-lane write
// masking and a built-in clear engine that zeroes the array after reset or on
// INIT_REQ. Reads are write-first; the output holds the word at the last
// accepted address while CEN is high.
// Optional macro AQ_F_SPSRAM_OUTREG_EN adds an output register (2-cycle read).
module aq_f_spsram_gen #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_B,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT_REQ,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_DONE
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     clr_addr_q, clr_addr_d;
    logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
    logic [DATA_WIDTH-1:0]   q1_q, q1_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   merged;
    logic [LANES-1:0]        lane_wr;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [LANES-1:0]        mem_wlane;

    // Only the MSB of each lane's mask field is meaningful.
    logic                    unused_wen_bits;
    assign unused_wen_bits = ^WEN;

    assign INIT_DONE = (state_q == ST_READY);

    // Single read port: idle cycles re-read the held address so Q tracks
    // the word at the last accepted address.
    assign rd_addr = CEN ? addr_hold_q : A;
    assign rd_word = mem[rd_addr];

    // Lane decode and write-first merge of D into the stored word.
    always_comb begin
        lane_wr = '0;
        merged  = rd_word;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_wr[i] = ~WEN[(i + 1) * LANE_WIDTH - 1];
            if (lane_wr[i]) begin
                merged[i * LANE_WIDTH +: LANE_WIDTH] = D[i * LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // State register plus clear counter, address hold and first read stage.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            addr_hold_q <= '0;
            q1_q        <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            addr_hold_q <= addr_hold_d;
            q1_q        <= q1_d;
        end
    end

    // Next-state and access control: clear walk, accesses, re-clear request.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        addr_hold_d = addr_hold_q;
        q1_d        = q1_q;
        mem_we      = 1'b0;
        mem_waddr   = A;
        mem_wdata   = merged;
        mem_wlane   = lane_wr;
        case (state_q)
            ST_CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q[ADDR_WIDTH-1:0];
                mem_wdata  = '0;
                mem_wlane  = '1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == CLR_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (INIT_REQ) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (!CEN) begin
                    addr_hold_d = A;
                    if (!GWEN) begin
                        mem_we = 1'b1;
                        q1_d   = merged;
                    end else begin
                        q1_d = rd_word;
                    end
                end else begin
                    q1_d = rd_word;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // Array write port with per-lane enables; contents are never reset.
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mem_we && mem_wlane[i]) begin
                mem[mem_waddr][i * LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[i * LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

`ifdef AQ_F_SPSRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] q2_q;

    // Extra output stage; holds naturally because stage one holds.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            q2_q <= '0;
        end else begin
            q2_q <= q1_q;
        end
    end

    assign Q = q2_q;
`else
    assign Q = q1_q;
`endif

endmodule

// File: tb/tb_aq_f_spsram_gen.sv
// Self-checking bench for aq_f_spsram_gen (ADDR_WIDTH=4) against a
// behavioural array model; honours AQ_F_SPSRAM_OUTREG_EN latency.
module tb_aq_f_spsram_gen;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int LW    = 8;
    localparam int DEPTH = 16;
    localparam int LANES = 4;
`ifdef AQ_F_SPSRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST_B = 1'b0;
    logic [AW-1:0] A = '0;
    logic          CEN = 1'b1;
    logic          GWEN = 1'b1;
    logic [DW-1:0] WEN = '1;
    logic [DW-1:0] D = '0;
    logic          INIT_REQ = 1'b0;
    logic [DW-1:0] Q;
    logic          INIT_DONE;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_q1;
    logic [DW-1:0] ref_q;
    bit            ref_ready;
    int            ref_cnt;
    int            ref_hold;

    always #5 CLK = ~CLK;

    aq_f_spsram_gen #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LANE_WIDTH(LW)
    ) dut (
        .CLK(CLK),
        .RST_B(RST_B),
        .A(A),
        .CEN(CEN),
        .GWEN(GWEN),
        .WEN(WEN),
        .D(D),
        .INIT_REQ(INIT_REQ),
        .Q(Q),
        .INIT_DONE(INIT_DONE)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_q1    = '0;
        ref_q     = '0;
        ref_ready = 1'b0;
        ref_cnt   = 0;
        ref_hold  = 0;
    endtask

    // One clock edge of the array as described by its rules.
    task automatic model_edge();
        logic [DW-1:0] word;
        logic [DW-1:0] q1_old;
        q1_old = ref_q1;
        if (!ref_ready) begin
            ref_mem[ref_cnt] = '0;
            if (ref_cnt == DEPTH - 1) ref_ready = 1'b1;
            ref_cnt++;
        end else if (INIT_REQ) begin
            ref_ready = 1'b0;
            ref_cnt   = 0;
        end else if (!CEN) begin
            word = ref_mem[A];
            if (!GWEN) begin
                for (int i = 0; i < LANES; i++) begin
                    if (WEN[i*LW+LW-1] == 1'b0) word[i*LW +: LW] = D[i*LW +: LW];
                end
            end
            ref_mem[A] = word;
            ref_q1     = word;
            ref_hold   = int'(A);
        end else begin
            ref_q1 = ref_mem[ref_hold];
        end
        ref_q = (LAT == 2) ? q1_old : ref_q1;
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        #1;
        model_edge();
        check({tag, ":q"}, Q, ref_q);
        check({tag, ":done"}, {31'b0, INIT_DONE}, {31'b0, ref_ready});
    endtask

    task automatic idle();
        CEN = 1'b1; GWEN = 1'b1; WEN = '1; INIT_REQ = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        CEN = 1'b0; GWEN = 1'b1; WEN = '1; INIT_REQ = 1'b0; A = a;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        CEN = 1'b0; GWEN = 1'b0; WEN = m; D = d; INIT_REQ = 1'b0; A = a;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Reset state
        model_reset();
        #2;
        check("rst:q", Q, '0);
        check("rst:done", {31'b0, INIT_DONE}, 32'd0);
        @(negedge CLK);
        RST_B = 1'b1;

        // Initial clear: DEPTH edges
        repeat (15) tick("clr0");
        check("clr0_edge15_done", {31'b0, INIT_DONE}, 32'd0);
        tick("clr0_last");
        check("clr0_edge16_done", {31'b0, INIT_DONE}, 32'd1);

        // Every address reads zero after the clear
        for (int a = 0; a < DEPTH; a++) begin
            rd(AW'(a));
            tick("rd_zero");
        end
        idle();
        tick("rd_zero_drain");
        check("rd_zero_last", Q, '0);

        // Full write then lane-1 partial write
        wr(4'd5, 32'hDEADBEEF, 32'h0000_0000);
        tick("w5_full");
        idle();
        tick("w5_full_idle");
        check("w5_full_val", Q, 32'hDEADBEEF);
        wr(4'd5, 32'h11223344, 32'hFFFF00FF);
        tick("w5_lane1");
        idle();
        tick("w5_lane1_idle");
        check("w5_lane1_val", Q, 32'hDEAD33EF);

        // Address hold over idle cycles with A toggling
        wr(4'd3, 32'hA5A5A5A5, 32'h0);
        tick("w3");
        rd(4'd3);
        tick("r3");
        idle();
        tick("r3_drain");
        for (int i = 0; i < 5; i++) begin
            A = AW'($urandom);
            tick("hold");
            check("hold_val", Q, 32'hA5A5A5A5);
        end

        // Back-to-back reads of distinct words
        wr(4'd1, 32'h01010101, 32'h0); tick("bb_w1");
        wr(4'd2, 32'h02020202, 32'h0); tick("bb_w2");
        wr(4'd3, 32'h03030303, 32'h0); tick("bb_w3");
        rd(4'd1); tick("bb_r1");
        rd(4'd2); tick("bb_r2");
        rd(4'd3); tick("bb_r3");
        idle();   tick("bb_d1");
        tick("bb_d2");
        check("bb_final", Q, 32'h03030303);

        // Randomized traffic with occasional re-clear requests
        for (int i = 0; i < 400; i++) begin
            CEN      = ($urandom_range(0, 3) == 0);
            GWEN     = $urandom_range(0, 1);
            WEN      = $urandom;
            D        = $urandom;
            A        = AW'($urandom);
            INIT_REQ = ($urandom_range(0, 99) < 2);
            tick("rand");
        end
        idle();
        guard = 0;
        while (!ref_ready && guard < 40) begin
            tick("rand_settle");
            guard++;
        end
        check("settle_ready", {31'b0, INIT_DONE}, 32'd1);

        // INIT_REQ together with a write: write dropped, array cleared
        wr(4'd7, 32'h12345678, 32'h0);
        tick("w7_pre");
        wr(4'd7, 32'hFFFFFFFF, 32'h0);
        INIT_REQ = 1'b1;
        tick("w7_ireq");
        check("ireq_done_fall", {31'b0, INIT_DONE}, 32'd0);
        idle();
        repeat (15) tick("reclr");
        check("reclr_15_done", {31'b0, INIT_DONE}, 32'd0);
        tick("reclr_last");
        check("reclr_16_done", {31'b0, INIT_DONE}, 32'd1);
        rd(4'd7);
        tick("r7");
        idle();
        tick("r7_drain");
        check("a7_cleared", Q, '0);

        // Reset in the middle of a clear at clr_addr=9
        wr(4'd3, 32'hA5A5A5A5, 32'h0);
        tick("w3b");
        idle();
        tick("w3b_d1");
        tick("w3b_d2");
        check("pre_rst_q", Q, 32'hA5A5A5A5);
        INIT_REQ = 1'b1;
        tick("ireq2");
        INIT_REQ = 1'b0;
        repeat (9) tick("clr_part");
        #2;
        RST_B = 1'b0;
        #1;
        model_reset();
        check("midrst:q", Q, '0);
        check("midrst:done", {31'b0, INIT_DONE}, 32'd0);
        @(negedge CLK);
        RST_B = 1'b1;
        repeat (15) tick("clr2");
        check("clr2_15_done", {31'b0, INIT_DONE}, 32'd0);
        tick("clr2_last");
        check("clr2_16_done", {31'b0, INIT_DONE}, 32'd1);
        rd(4'd3);
        tick("r3_after");
        idle();
        tick("r3_after_drain");
        check("r3_after_val", Q, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
